// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: parametrised APB register bank with wait states, error checks and a core read port.
// Define APB_REGBANK_STATUS_EN to add a read-only status word just past the bank.
module apb_regbank_slave #(
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  localparam int STRB_W     = BUS_WIDTH / 8,
  localparam int LSB        = $clog2(STRB_W),
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [STRB_W-1:0]     pstrb_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  busy_o,
  input  logic [IDX_W-1:0]      core_idx_i,
  output logic [BUS_WIDTH-1:0]  core_data_o,
  output logic                  wr_pulse_o
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr;
  logic write_q, write;
  logic [STRB_W-1:0] strb_q, strb;
  logic [BUS_WIDTH-1:0] wdata_q, rdata;
  logic [BUS_WIDTH-1:0] regs [DEPTH];
  logic [3:0] cnt;
  logic [IDX_W-1:0] idx;
  logic setup, done, abort, rise, misalign, oor, err;
`ifdef APB_REGBANK_STATUS_EN
  logic stat, flag;
  logic [7:0] errs;
`endif
  assign setup = state == IDLE && psel_i && !penable_i;
  assign done  = state == ACCESS && pready_o && psel_i && penable_i;
  assign abort = state == ACCESS && !psel_i;
  assign rise  = (setup && WAIT_STATES == 0) || (state == ACCESS && psel_i && cnt == 4'd1);
  // Decode the live bus at the setup edge (zero-wait completes there), the latched copy afterwards.
  assign addr  = setup ? paddr_i : addr_q;
  assign write = setup ? pwrite_i : write_q;
  assign strb  = setup ? pstrb_i : strb_q;
  assign idx      = IDX_W'(addr >> LSB);
  assign misalign = (addr & ADDR_WIDTH'(STRB_W - 1)) != '0;
  assign oor      = (addr >> (LSB + IDX_W)) != '0;
`ifdef APB_REGBANK_STATUS_EN
  assign stat  = !misalign && (addr >> LSB) == ADDR_WIDTH'(DEPTH);
  assign err   = misalign || (oor && !stat) || (!write && strb != '0) || (stat && write);
  assign rdata = stat ? BUS_WIDTH'({errs, flag}) : regs[idx];
`else
  assign err   = misalign || oor || (!write && strb != '0);
  assign rdata = regs[idx];
`endif
  assign core_data_o = regs[core_idx_i];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (setup ? ACCESS : IDLE) : (done || abort ? IDLE : ACCESS);
  end
  always_comb begin
    busy_o = state == ACCESS;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      strb_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      pready_o   <= 1'b0;
      pslverr_o  <= 1'b0;
      prdata_o   <= '0;
      wr_pulse_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
`ifdef APB_REGBANK_STATUS_EN
      flag <= 1'b0;
      errs <= '0;
`endif
    end else begin
      wr_pulse_o <= 1'b0;
      if (setup) begin
        addr_q  <= paddr_i;
        write_q <= pwrite_i;
        strb_q  <= pstrb_i;
        wdata_q <= pwdata_i;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == ACCESS && cnt != '0) cnt <= cnt - 4'd1;
      if (rise) begin
        pready_o  <= 1'b1;
        pslverr_o <= err;
        if (!write || err) prdata_o <= err ? '0 : rdata;
      end
      if (done || abort) begin
        pready_o  <= 1'b0;
        pslverr_o <= 1'b0;
      end
      if (done && !err && write) begin
        wr_pulse_o <= 1'b1;
        for (int k = 0; k < STRB_W; k++)
          if (strb_q[k]) regs[idx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
`ifdef APB_REGBANK_STATUS_EN
      if (abort) flag <= 1'b1;
      else if (done && !err && !write && stat) flag <= 1'b0;
      if (done && err && errs != 8'hFF) errs <= errs + 8'd1;
`endif
    end
  end
endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb_apb_regbank_slave: scoreboard bench for a zero-wait and a three-wait instance of the register bank.
module tb_apb_regbank_slave;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] psel = '0;
  logic penable = 1'b0, pwrite = 1'b0;
  logic [3:0] pstrb = '0, cidx = '0;
  logic [31:0] pwdata = '0;
  logic [15:0] paddr = '0;
  logic rdy [2], serr [2], busy [2], wp [2];
  logic [31:0] rdata [2], cdata [2];
  apb_regbank_slave #(.WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel[0]), .penable_i(penable), .pwrite_i(pwrite),
    .pstrb_i(pstrb), .pwdata_i(pwdata), .paddr_i(paddr), .pready_o(rdy[0]), .pslverr_o(serr[0]),
    .prdata_o(rdata[0]), .busy_o(busy[0]), .core_idx_i(cidx), .core_data_o(cdata[0]), .wr_pulse_o(wp[0]));
  apb_regbank_slave #(.WAIT_STATES(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel[1]), .penable_i(penable), .pwrite_i(pwrite),
    .pstrb_i(pstrb), .pwdata_i(pwdata), .paddr_i(paddr), .pready_o(rdy[1]), .pslverr_o(serr[1]),
    .prdata_o(rdata[1]), .busy_o(busy[1]), .core_idx_i(cidx), .core_data_o(cdata[1]), .wr_pulse_o(wp[1]));
  int checks = 0, errors = 0;
  logic [31:0] model [2][16];
  typedef struct {logic err; logic rd; logic [31:0] data; int ws;} exp_t;
  exp_t q [$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic clear_model();
    for (int n = 0; n < 2; n++) for (int i = 0; i < 16; i++) model[n][i] = '0;
  endtask
  task automatic xfer(input int n, input logic w, input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
    exp_t e, g;
    int waits = 0;
    e.err  = a[1:0] != 2'b0 || a[15:6] != 10'b0 || (!w && s != 4'b0);
    e.rd   = !w;
    e.data = e.err ? 32'h0 : model[n][a[5:2]];
    e.ws   = n ? 3 : 0;
    q.push_back(e);
    cidx = a[5:2];
    @(negedge clk);
    psel[n] = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pstrb = s; pwdata = d;
    @(negedge clk);
    penable = 1'b1; paddr = 16'($urandom); pwdata = $urandom;
    while (!rdy[n] && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    g = q.pop_front();
    chk("wait_cycles", 32'(waits), 32'(g.ws));
    chk("busy_active", 32'(busy[n]), 32'd1);
    chk("pslverr", 32'(serr[n]), 32'(g.err));
    if (g.rd || g.err) chk("prdata", rdata[n], g.data);
    chk("pulse_early", 32'(wp[n]), 32'd0);
    @(negedge clk);
    psel[n] = 1'b0; penable = 1'b0;
    if (w && !g.err)
      for (int k = 0; k < 4; k++) if (s[k]) model[n][a[5:2]][8*k +: 8] = d[8*k +: 8];
    chk("wr_pulse", 32'(wp[n]), 32'(w && !g.err));
    chk("busy_idle", 32'(busy[n]), 32'd0);
    chk("ready_low", 32'(rdy[n]), 32'd0);
    chk("core_data", cdata[n], model[n][a[5:2]]);
  endtask
  initial begin
    logic w;
    logic [15:0] a;
    logic [3:0] s;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_busy", 32'(busy[1]), 32'd0);
    chk("rst_prdata", rdata[0], 32'd0);
    cidx = 4'd1;
    #1 chk("rst_core", cdata[0], 32'd0);
    rst_n = 1'b1;
    xfer(0, 1'b1, 16'h0004, 4'hF, 32'hDEADBEEF);
    chk("full_write", cdata[0], 32'hDEADBEEF);
    xfer(0, 1'b1, 16'h0004, 4'h2, 32'h0000AA00);
    chk("partial_write", cdata[0], 32'hDEADAAEF);
    xfer(0, 1'b0, 16'h0004, 4'h0, 32'h0);
    xfer(1, 1'b1, 16'h0008, 4'hF, 32'h12345678);
    xfer(1, 1'b0, 16'h0008, 4'h0, 32'h0);
    xfer(0, 1'b0, 16'h0040, 4'h0, 32'h0);
    xfer(0, 1'b1, 16'h0002, 4'hF, 32'hFFFFFFFF);
    xfer(0, 1'b0, 16'h0004, 4'h1, 32'h0);
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 80));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b0;
      s = (w || $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      xfer($urandom_range(0, 1), w, a, s, $urandom);
    end
    xfer(1, 1'b1, 16'h0008, 4'hF, 32'hCAFEF00D);
    cidx = 4'd2;
    @(negedge clk);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008; pstrb = 4'hF; pwdata = 32'hAAAA5555;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel[1] = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy[1]), 32'd0);
    chk("abort_ready", 32'(rdy[1]), 32'd0);
    chk("abort_pulse", 32'(wp[1]), 32'd0);
    chk("abort_nowrite", cdata[1], 32'hCAFEF00D);
    xfer(1, 1'b0, 16'h0008, 4'h0, 32'h0);
    @(negedge clk);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0008; pstrb = 4'h0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy[1]), 32'd0);
    chk("rst_mid_ready", 32'(rdy[1]), 32'd0);
    chk("rst_mid_prdata", rdata[1], 32'd0);
    chk("rst_mid_core", cdata[1], 32'd0);
    psel = '0; penable = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, 16'h0008, 4'h0, 32'h0);
    xfer(1, 1'b1, 16'h003C, 4'h9, 32'h11223344);
    xfer(1, 1'b0, 16'h003C, 4'h0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_regbank_slave.md
Name: apb_regbank_slave

Overview:
- Parametrised APB slave register bank. It is the next generation of the matmul-side APB slave.
- Generalises data width, depth and byte strobes, and adds programmable wait states, address/strobe error checking, abort on protocol violation, and a core-side read port.
- Sits between the APB master and the matmul core, which reads configuration/operand words through the core port.

Parameters:
- BUS_WIDTH, 32, APB data width in bits; multiple of 8, 8..128.
- ADDR_WIDTH, 16, APB address width.
- DEPTH, 16, number of BUS_WIDTH-bit registers; power of 2, >=2.
- WAIT_STATES, 0, extra access cycles before pready_o asserts; 0..15.
- Derived: STRB_W=BUS_WIDTH/8, LSB=log2(STRB_W), IDX_W=log2(DEPTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- pwrite_i  in  1  1=write, 0=read.
- pstrb_i  in  STRB_W  byte write strobes.
- pwdata_i  in  BUS_WIDTH  write data.
- paddr_i  in  ADDR_WIDTH  byte address.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error; valid only with pready_o.
- prdata_o  out  BUS_WIDTH  read data; valid with pready_o on reads.
- busy_o  out  1  transfer in progress.
- core_idx_i  in  IDX_W  core read index.
- core_data_o  out  BUS_WIDTH  register[core_idx_i], combinational.
- wr_pulse_o  out  1  one-cycle pulse when a register is committed.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; all registers 0.
  - pready_o=0, pslverr_o=0, prdata_o=0, busy_o=0, wr_pulse_o=0, wait counter 0.
  - Reset mid-transfer aborts it with no write.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On psel_i=1 & penable_i=0 (setup): latch addr, pwrite, strb, wdata; compute err; load cnt=WAIT_STATES; go to ACCESS; busy_o<=1.
  - If WAIT_STATES=0, also pready_o<=1 at that edge (zero-wait: the first access cycle completes).
  - psel_i=1 & penable_i=1 seen in IDLE is ignored.
- ACCESS:
  - If cnt!=0: cnt<=cnt-1; pready_o<=1 on the edge where cnt goes 1->0.
  - Completion edge is pready_o=1 & psel_i=1 & penable_i=1. At that edge: commit write (if no err), wr_pulse_o<=1, pready_o<=0, pslverr_o<=0, busy_o<=0, go to IDLE.
  - prdata_o and pslverr_o are registered together with pready_o: they are loaded on the edge pready_o rises, and prdata_o holds until the next read completes.
- Error (err=1, checked on latched values):
  - addr[LSB-1:0]!=0, or
  - addr[ADDR_WIDTH-1:LSB+IDX_W]!=0 (out of range), or
  - read with pstrb!=0.
  - On error: pslverr_o=1 with pready_o; no register modified; prdata_o=0; wr_pulse_o stays 0.
- Write commit: for each byte k with strb[k]=1, reg[idx][8k+7:8k]<=wdata byte k; other bytes unchanged. strb=0 is a legal no-op write and still pulses wr_pulse_o.
- Protocol violation: psel_i=0 while in ACCESS.
  - Abort to IDLE at that edge; no write; pready_o=0, busy_o=0, pslverr_o=0.
  - Sticky flag, readable only in the option below.
- Back-to-back: a new setup is accepted in the cycle after completion (IDLE), so minimum transfer is 2 cycles.
- core_data_o reflects committed values; a write is visible the cycle after commit.
- Master changing pwdata_i or paddr_i after setup has no effect (latched).

Optional Feature:
- APB_REGBANK_STATUS_EN defined:
  - Address DEPTH*STRB_W (the word just past the bank) is a read-only status word: bit0=sticky protocol-abort flag, bits[8:1]=count of error completions, saturating at 255.
  - Reading it clears bit0; the counter is not cleared.
  - Writes to this address complete with pslverr_o=1.
- Not defined: that address is out of range (error); no flag or counter logic is synthesised.

Test Plan:
- Reset then zero-wait write, addr 0x4, data 0xDEADBEEF, strb 0xF -> pready_o=1 in the first access cycle; wr_pulse_o pulses; core_data_o(idx1)=0xDEADBEEF next cycle.
- Partial write strb 0x2, data 0x0000AA00 to idx1 -> register = 0xDEADAAEF; read back gives prdata_o=0xDEADAAEF, pslverr_o=0.
- WAIT_STATES=3 read -> pready_o low for 3 access cycles, high on the 4th; busy_o high from setup edge to completion edge.
- Errors with DEPTH=16:
  - Read addr 0x40 -> pslverr_o=1, prdata_o=0.
  - Write addr 0x2 -> pslverr_o=1, no register change.
  - Read with strb 0x1 -> pslverr_o=1.
- psel_i dropped in the 2nd access cycle of a WAIT_STATES=2 write -> FSM returns to IDLE, no write, no wr_pulse_o.
  - With APB_REGBANK_STATUS_EN: status read returns bit0=1; a second read returns bit0=0.
- Assert rst_ni mid-ACCESS -> all outputs 0 immediately; registers 0; next transfer behaves normally.
